// File: rtl/hash_key_packer.sv
// hash_key_packer: buffers a byte-streamed memcache key, then replays it as
// 12-byte little-endian blocks (k0/k1/k2) tagged with the total key length.
// Storage is twelve byte lanes, each BLOCKS deep, so a whole block is read in
// one cycle. Keys longer than MAX_LEN are swallowed and reported on err_drop.
module hash_key_packer #(
    parameter int MAX_LEN = 250
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  key_length,
    output logic [31:0] k0,
    output logic [31:0] k1,
    output logic [31:0] k2,
    output logic [3:0]  out_bytes,
    output logic        out_first,
    output logic        out_last,
    output logic        err_drop
);

    localparam int BLOCKS = (MAX_LEN + 11) / 12;
    // One spare code so the write address may step one past the last block
    // while the key is being counted towards the overflow point.
    localparam int BLK_W  = $clog2(BLOCKS + 1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_EMIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    // Control state
    state_t             state_q, state_d;
    logic [7:0]         n_q, n_d;
    logic [BLK_W-1:0]   wr_addr_q, wr_addr_d;
    logic [3:0]         wr_lane_q, wr_lane_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic [BLK_W-1:0]   last_blk_q, last_blk_d;
    logic [3:0]         last_bytes_q, last_bytes_d;

    // Registered outputs
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               out_first_q, out_first_d;
    logic               out_last_q, out_last_d;
    logic [3:0]         out_bytes_q, out_bytes_d;
    logic [7:0]         key_length_q, key_length_d;
    logic [31:0]        k0_q, k0_d;
    logic [31:0]        k1_q, k1_d;
    logic [31:0]        k2_q, k2_d;
    logic               err_drop_q, err_drop_d;

    // Datapath control produced by the FSM
    logic               wr_en;
    logic               load;
    logic               clear;
    logic [BLK_W-1:0]   rd_addr;
    logic [7:0]         lane_rd [12];
    logic [95:0]        blk_data;

    logic               byte_acc;
    logic               blk_xfer;

    assign byte_acc = in_valid & in_ready_q;
    assign blk_xfer = out_valid_q & out_ready;

    // Byte-lane storage. The byte being written in the same cycle that block 0
    // is loaded (a key's final byte) is forwarded so no extra cycle is needed.
    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_lane
            logic [7:0] mem [BLOCKS];

            // Write the incoming byte into its lane at the current block address
            always_ff @(posedge CLK) begin
                if (wr_en && (wr_lane_q == 4'(gi))) begin
                    mem[wr_addr_q] <= in_data;
                end
            end

            assign lane_rd[gi] = (wr_en && (wr_lane_q == 4'(gi)) && (wr_addr_q == rd_addr))
                                 ? in_data : mem[rd_addr];
        end
    endgenerate

    // FSM next-state and byte/block bookkeeping
    always_comb begin
        state_d      = state_q;
        n_d          = n_q;
        wr_addr_d    = wr_addr_q;
        wr_lane_d    = wr_lane_q;
        blk_d        = blk_q;
        last_blk_d   = last_blk_q;
        last_bytes_d = last_bytes_q;
        key_length_d = key_length_q;
        err_drop_d   = 1'b0;
        wr_en        = 1'b0;
        load         = 1'b0;
        clear        = 1'b0;
        rd_addr      = blk_q;

        case (state_q)
            S_FILL: begin
                if (byte_acc) begin
                    if (n_q == 8'(MAX_LEN)) begin
                        // Overflow byte: never stored, counters restart.
                        n_d       = '0;
                        wr_addr_d = '0;
                        wr_lane_d = '0;
                        if (in_last) begin
                            err_drop_d = 1'b1;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else begin
                        wr_en = 1'b1;
                        if (in_last) begin
                            key_length_d = n_q + 8'd1;
                            last_blk_d   = wr_addr_q;
                            last_bytes_d = wr_lane_q + 4'd1;
                            blk_d        = '0;
                            rd_addr      = '0;
                            load         = 1'b1;
                            state_d      = S_EMIT;
                            n_d          = '0;
                            wr_addr_d    = '0;
                            wr_lane_d    = '0;
                        end else begin
                            n_d = n_q + 8'd1;
                            if (wr_lane_q == 4'd11) begin
                                wr_lane_d = '0;
                                wr_addr_d = wr_addr_q + BLK_W'(1);
                            end else begin
                                wr_lane_d = wr_lane_q + 4'd1;
                            end
                        end
                    end
                end
            end

            S_DROP: begin
                if (byte_acc && in_last) begin
                    err_drop_d = 1'b1;
                    state_d    = S_FILL;
                end
            end

            S_EMIT: begin
                if (blk_xfer) begin
                    if (out_last_q) begin
                        state_d      = S_FILL;
                        clear        = 1'b1;
                        key_length_d = '0;
                    end else begin
                        blk_d   = blk_q + BLK_W'(1);
                        rd_addr = blk_q + BLK_W'(1);
                        load    = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase

        in_ready_d = (state_d != S_EMIT);
    end

    // Block output assembly: load a new block, clear after the last one, else hold
    always_comb begin
        out_valid_d = out_valid_q;
        out_first_d = out_first_q;
        out_last_d  = out_last_q;
        out_bytes_d = out_bytes_q;
        k0_d        = k0_q;
        k1_d        = k1_q;
        k2_d        = k2_q;
        blk_data    = '0;

        if (load) begin
            out_valid_d = 1'b1;
            out_first_d = (rd_addr == '0);
            out_last_d  = (rd_addr == last_blk_d);
            out_bytes_d = (rd_addr == last_blk_d) ? last_bytes_d : 4'd12;
            // Bytes beyond the key are masked here; storage keeps stale data.
            for (int l = 0; l < 12; l++) begin
                blk_data[8*l +: 8] = (4'(l) < out_bytes_d) ? lane_rd[l] : 8'h00;
            end
            k0_d = blk_data[31:0];
            k1_d = blk_data[63:32];
            k2_d = blk_data[95:64];
        end else if (clear) begin
            out_valid_d = 1'b0;
            out_first_d = 1'b0;
            out_last_d  = 1'b0;
            out_bytes_d = '0;
            k0_d        = '0;
            k1_d        = '0;
            k2_d        = '0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= S_FILL;
            n_q          <= '0;
            wr_addr_q    <= '0;
            wr_lane_q    <= '0;
            blk_q        <= '0;
            last_blk_q   <= '0;
            last_bytes_q <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_bytes_q  <= '0;
            key_length_q <= '0;
            k0_q         <= '0;
            k1_q         <= '0;
            k2_q         <= '0;
            err_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_q          <= n_d;
            wr_addr_q    <= wr_addr_d;
            wr_lane_q    <= wr_lane_d;
            blk_q        <= blk_d;
            last_blk_q   <= last_blk_d;
            last_bytes_q <= last_bytes_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            out_bytes_q  <= out_bytes_d;
            key_length_q <= key_length_d;
            k0_q         <= k0_d;
            k1_q         <= k1_d;
            k2_q         <= k2_d;
            err_drop_q   <= err_drop_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_first  = out_first_q;
    assign out_last   = out_last_q;
    assign out_bytes  = out_bytes_q;
    assign key_length = key_length_q;
    assign k0         = k0_q;
    assign k1         = k1_q;
    assign k2         = k2_q;
    assign err_drop   = err_drop_q;

endmodule

// File: tb/tb_hash_key_packer.sv
// Testbench for hash_key_packer: directed keys from the block's intended use
// plus randomized keys, compared against a byte-array reference model.
module tb_hash_key_packer;

    localparam int MAX_LEN = 250;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  key_length;
    logic [31:0] k0, k1, k2;
    logic [3:0]  out_bytes;
    logic        out_first;
    logic        out_last;
    logic        err_drop;

    always #5 CLK = ~CLK;

    hash_key_packer #(.MAX_LEN(MAX_LEN)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .key_length (key_length),
        .k0         (k0),
        .k1         (k1),
        .k2         (k2),
        .out_bytes  (out_bytes),
        .out_first  (out_first),
        .out_last   (out_last),
        .err_drop   (err_drop)
    );

    int tests = 0;
    int fails = 0;
    int xfer_cnt = 0;
    int drop_cnt = 0;
    int exp_xfers = 0;
    int exp_drops = 0;

    logic [7:0] key_mem [0:299];

    // Count block transfers and drop pulses seen by the downstream
    always @(posedge CLK) begin
        if (!RST && out_valid && out_ready) xfer_cnt <= xfer_cnt + 1;
        if (!RST && err_drop) drop_cnt <= drop_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: byte i of the key lands at block i/12, byte position i%12.
    function automatic logic [31:0] exp_word(input int len, input int b, input int w);
        logic [31:0] word;
        word = '0;
        for (int j = 0; j < 4; j++) begin
            int idx;
            idx = 12 * b + 4 * w + j;
            if (idx < len) word[8*j +: 8] = key_mem[idx];
        end
        return word;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_k0"}, k0, 0);
        chk({tag, "_k1"}, k1, 0);
        chk({tag, "_k2"}, k2, 0);
        chk({tag, "_klen"}, key_length, 0);
        chk({tag, "_bytes"}, out_bytes, 0);
        chk({tag, "_first"}, out_first, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_drop"}, err_drop, 0);
    endtask

    task automatic check_block(input int len, input int b);
        int nb;
        int eb;
        nb = (len + 11) / 12;
        eb = (b == nb - 1) ? (len - 12 * b) : 12;
        chk($sformatf("valid_L%0d_b%0d", len, b), out_valid, 1);
        chk($sformatf("k0_L%0d_b%0d", len, b), k0, exp_word(len, b, 0));
        chk($sformatf("k1_L%0d_b%0d", len, b), k1, exp_word(len, b, 1));
        chk($sformatf("k2_L%0d_b%0d", len, b), k2, exp_word(len, b, 2));
        chk($sformatf("klen_L%0d_b%0d", len, b), key_length, len);
        chk($sformatf("bytes_L%0d_b%0d", len, b), out_bytes, eb);
        chk($sformatf("first_L%0d_b%0d", len, b), out_first, (b == 0) ? 1 : 0);
        chk($sformatf("last_L%0d_b%0d", len, b), out_last, (b == nb - 1) ? 1 : 0);
    endtask

    // Present one byte at a falling edge and wait (bounded) until it is taken.
    task automatic send_byte(input logic [7:0] d, input logic last);
        logic rdy;
        bit   ok;
        ok       = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        for (int c = 0; c < 1000; c++) begin
            rdy = in_ready;
            @(negedge CLK);
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic send_key(input int len, input bit gaps);
        for (int i = 0; i < len; i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) @(negedge CLK);
            send_byte(key_mem[i], (i == len - 1));
        end
    endtask

    // mode 0: always ready, 1: a stall cycle before every block, 2: random stalls
    task automatic recv_key(input int len, input int mode);
        int nb;
        nb = (len + 11) / 12;
        chk($sformatf("busy_L%0d", len), in_ready, 0);
        for (int b = 0; b < nb; b++) begin
            if (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1)) begin
                out_ready = 1'b0;
                check_block(len, b);
                @(negedge CLK);
            end
            out_ready = 1'b1;
            check_block(len, b);
            @(negedge CLK);
        end
        out_ready = 1'b0;
        chk($sformatf("done_valid_L%0d", len), out_valid, 0);
        chk($sformatf("done_ready_L%0d", len), in_ready, 1);
        exp_xfers += nb;
    endtask

    task automatic run_key(input int len, input bit gaps, input int mode);
        send_key(len, gaps);
        if (len <= MAX_LEN) begin
            recv_key(len, mode);
        end else begin
            chk($sformatf("drop_pulse_L%0d", len), err_drop, 1);
            chk($sformatf("drop_novalid_L%0d", len), out_valid, 0);
            chk($sformatf("drop_ready_L%0d", len), in_ready, 1);
            exp_drops++;
        end
    endtask

    initial begin
        RST       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge CLK);
        check_zero("rst");
        chk("rst_in_ready", in_ready, 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_in_ready", in_ready, 1);

        // "abc" -> single 3-byte block
        key_mem[0] = 8'h61; key_mem[1] = 8'h62; key_mem[2] = 8'h63;
        send_key(3, 0);
        chk("abc_k0_const", k0, 32'h00636261);
        recv_key(3, 0);

        // Exactly one full block
        for (int i = 0; i < 12; i++) key_mem[i] = 8'(i);
        send_key(12, 0);
        chk("b12_k2_const", k2, 32'h0B0A0908);
        recv_key(12, 0);

        // 13 bytes -> two consecutive blocks
        for (int i = 0; i < 13; i++) key_mem[i] = 8'(i);
        run_key(13, 0, 0);

        // Maximum length with alternating backpressure
        for (int i = 0; i < MAX_LEN; i++) key_mem[i] = 8'($urandom);
        run_key(MAX_LEN, 0, 1);

        // One byte too long, then a 1-byte key straight after
        for (int i = 0; i < MAX_LEN + 1; i++) key_mem[i] = 8'($urandom);
        run_key(MAX_LEN + 1, 0, 0);
        key_mem[0] = 8'h7A;
        run_key(1, 0, 0);
        chk("drop_count_a", drop_cnt, exp_drops);

        // Reset while block 1 of a 30-byte key is stalled
        for (int i = 0; i < 30; i++) key_mem[i] = 8'($urandom);
        send_key(30, 0);
        out_ready = 1'b1;
        check_block(30, 0);
        @(negedge CLK);
        out_ready = 1'b0;
        check_block(30, 1);
        @(negedge CLK);
        check_block(30, 1);
        exp_xfers += 1;
        RST = 1'b1;
        @(negedge CLK);
        check_zero("rst_emit");
        chk("rst_emit_in_ready", in_ready, 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_emit_after_ready", in_ready, 1);
        chk("rst_emit_after_valid", out_valid, 0);

        // Reset mid-fill, then a fresh key must start at byte 0
        for (int i = 0; i < 5; i++) send_byte(8'hEE, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) key_mem[i] = 8'($urandom);
        run_key(4, 0, 0);

        // Reset mid-drop, then a normal key
        for (int i = 0; i < MAX_LEN + 3; i++) send_byte(8'h55, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 7; i++) key_mem[i] = 8'($urandom);
        run_key(7, 0, 0);

        // Randomized keys, gaps and backpressure
        for (int t = 0; t < 25; t++) begin
            int sel;
            int len;
            sel = $urandom_range(0, 9);
            if (sel < 6)      len = $urandom_range(1, 40);
            else if (sel < 9) len = $urandom_range(200, MAX_LEN);
            else              len = $urandom_range(MAX_LEN + 1, MAX_LEN + 8);
            for (int i = 0; i < len; i++) key_mem[i] = 8'($urandom);
            run_key(len, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        @(negedge CLK);
        chk("xfer_count", xfer_cnt, exp_xfers);
        chk("drop_count", drop_cnt, exp_drops);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hash_key_packer.md
# hash_key_packer

Front-end stage of the key-hash datapath. It accepts a memcache key as a byte stream from the protocol parser and buffers the whole key, because the hash pipeline needs the final key length before the first block. It then emits the key as consecutive 12-byte little-endian blocks (k0/k1/k2) with key_length, in the packing order the Jenkins hash pipeline consumes.

## Interface
Parameters
- MAX_LEN, 250: maximum accepted key length in bytes; must be ≤ 255. Block storage depth is BLOCKS = ceil(MAX_LEN/12), which is 21 by default.

Ports
- CLK  in  1  single clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data carries a key byte.
- in_data  in  8  key byte, in key order.
- in_last  in  1  final byte of the key.
- in_ready  out  1  packer accepts a byte this cycle.
- out_valid  out  1  block outputs are valid.
- out_ready  in  1  downstream takes the block.
- key_length  out  8  total key length in bytes, constant on every block of a key.
- k0, k1, k2  out  32 each  block words.
- out_bytes  out  4  number of valid bytes in this block, 1..12.
- out_first  out  1  first block of the key.
- out_last  out  1  final block of the key.
- err_drop  out  1  one-cycle pulse: the key exceeded MAX_LEN and was discarded.

## Operation
- A byte transfers on in_valid & in_ready. A block transfers on out_valid & out_ready.
- States:
  - FILL: in_ready=1. Each accepted byte is written at index n, and n increments.
  - EMIT: in_ready=0, out_valid=1.
  - DROP: in_ready=1. Bytes are consumed and discarded.
- Byte packing: byte i goes to block i/12, word (i%12)/4, bits [8*(i%4)+7 : 8*(i%4)]. k0 holds bytes 0-3, k1 bytes 4-7, k2 bytes 8-11.
- Transitions:
  - FILL, byte accepted with in_last and n+1 ≤ MAX_LEN: latch key_length=n+1, set blk=0, go to EMIT.
  - FILL, byte accepted with n+1 > MAX_LEN: discard the byte. If in_last is also set, pulse err_drop and stay in FILL with n=0. Otherwise go to DROP.
  - DROP, byte accepted with in_last: pulse err_drop, go to FILL with n=0.
  - EMIT, block transfers with out_last: go to FILL with n=0. Otherwise blk increments.
- Per-block outputs:
  - out_first = (blk==0).
  - out_last = (blk == ceil(key_length/12)-1).
  - out_bytes = 12 for non-final blocks, otherwise key_length - 12*blk.
- Bytes at positions ≥ out_bytes are driven as 0. Masking is done at the output, so storage is never cleared between keys.
- in_valid is ignored while in_ready=0. The upstream holds its byte until accepted.
- Zero-length keys cannot be expressed: every transfer carries one byte.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, out_valid=0, err_drop=0, out_first=0, out_last=0, out_bytes=0, key_length=0, k0/k1/k2=0. State is FILL with n=0.
- in_ready=1 on the first cycle after RST deasserts.
- Latency: out_valid rises the cycle after the in_last byte is accepted. Block 0 is presented at that point.
- Block rate: with out_ready held at 1, one block per cycle. A key of L bytes occupies ceil(L/12) cycles in EMIT.
- in_ready returns to 1 on the cycle after the out_last transfer. There are no bubbles beyond that cycle.
- Backpressure: while out_valid=1 and out_ready=0, every block output holds stable.
- err_drop pulses on the cycle after the offending in_last is accepted. out_valid stays 0 for a dropped key.
- RST asserted mid-FILL, mid-EMIT or mid-DROP aborts the key. The next cycle shows reset values and no partial block is ever emitted.
- A key of exactly MAX_LEN bytes is accepted. A key of MAX_LEN+1 bytes is dropped.

## Test plan
- Bytes 0x61, 0x62, 0x63 (last on 0x63), out_ready=1 → one block:
  - k0=0x00636261, k1=0, k2=0.
  - key_length=3, out_bytes=3, out_first=1, out_last=1.
- Bytes 0x00..0x0B (12 bytes) → one block:
  - k0=0x03020100, k1=0x07060504, k2=0x0B0A0908.
  - out_bytes=12, out_first=1, out_last=1.
- Bytes 0x00..0x0C (13 bytes) → two blocks on consecutive cycles:
  - Block 2: k0=0x0000000C, k1=0, k2=0, out_bytes=1, out_last=1.
  - key_length=13 on both blocks.
- 250-byte key with out_ready toggling 1,0,1,0 → 21 blocks, each held stable while out_ready=0.
  - Last block has out_bytes=10.
  - in_ready=1 on the cycle after the final transfer.
- 251-byte key, followed immediately by a 1-byte key 0x7A:
  - err_drop pulses once and no out_valid for the 251-byte key.
  - The next key yields k0=0x0000007A and key_length=1.
- RST asserted while block 1 of a 30-byte key is stalled (out_ready=0) → the next cycle has out_valid=0 and all outputs zero, then in_ready=1.
